// File: rtl/uart_game_decoder_pkg.sv
//------------------------------------------------------------------------------
// uart_game_pkg: shared frame layout, field widths and reserved-bit masks
// for the game-state UART link. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_game_pkg;

  localparam int FRAME_LEN = 11;

  localparam int POS_W = 12;
  localparam int CHP_W = 4;
  localparam int BHP_W = 7;

  typedef enum logic [3:0] {
    IDX_CX_L = 4'd0,
    IDX_CX_H = 4'd1,
    IDX_CY_L = 4'd2,
    IDX_CY_H = 4'd3,
    IDX_CHP  = 4'd4,
    IDX_BHP  = 4'd5,
    IDX_BX_L = 4'd6,
    IDX_BX_H = 4'd7,
    IDX_BY_L = 4'd8,
    IDX_BY_H = 4'd9,
    IDX_GND  = 4'd10
  } byte_idx_t;

  localparam logic [7:0] RSVD_NONE = 8'h00;
  localparam logic [7:0] RSVD_HI   = 8'hF0;
  localparam logic [7:0] RSVD_BHP  = 8'h80;
  localparam logic [7:0] RSVD_GND  = 8'hFE;

  // Bits that must be zero in the byte at a given frame position.
  function automatic logic [7:0] rsvd_mask(input byte_idx_t idx);
    case (idx)
      IDX_CX_H, IDX_CY_H, IDX_CHP, IDX_BX_H, IDX_BY_H: rsvd_mask = RSVD_HI;
      IDX_BHP:                                         rsvd_mask = RSVD_BHP;
      IDX_GND:                                         rsvd_mask = RSVD_GND;
      default:                                         rsvd_mask = RSVD_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_game_decoder_if.sv
//------------------------------------------------------------------------------
// uart_game_rx_if: RX FIFO head/pop handshake between FIFO and decoder.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_game_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_empty;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  uart_rd;

  modport master (output rx_empty, output rx_data, input  uart_rd);
  modport slave  (input  rx_empty, input  rx_data, output uart_rd);
endinterface

`default_nettype wire

// File: rtl/uart_game_decoder_timeout.sv
//------------------------------------------------------------------------------
// uart_game_timeout: reloadable down-counter; o_expire pulses on the
// TIMEOUT-th consecutive enabled cycle since the last clear. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_game_timeout #(
  parameter int TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_expire
);

  localparam int               CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_rem;

  // Clear has priority, so a clear in the expiring cycle suppresses the pulse.
  assign o_expire = i_en && !i_clr && (r_rem == '0);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_rem <= LOAD;
    end else if (i_en) begin
      r_rem <= (r_rem == '0) ? LOAD : r_rem - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_game_decoder.sv
//------------------------------------------------------------------------------
// uart_game_decoder: reassembles 11-byte game frames from the UART RX FIFO
// and publishes them atomically. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_game_decoder
  import uart_game_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int GAP_TIMEOUT  = 200_000,
  parameter int LINK_TIMEOUT = 6_500_000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  uart_game_rx_if.slave   rx,
  output logic [POS_W-1:0] o_char_x,
  output logic [POS_W-1:0] o_char_y,
  output logic [CHP_W-1:0] o_char_hp,
  output logic [BHP_W-1:0] o_boss_hp,
  output logic [POS_W-1:0] o_boss_x,
  output logic [POS_W-1:0] o_boss_y,
  output logic             o_on_ground,
  output logic             o_frame_valid,
  output logic             o_frame_err,
  output logic [7:0]       o_err_cnt,
  output logic             o_link_up
);

  byte_idx_t        r_idx;
  logic [POS_W-1:0] r_sh_cx, r_sh_cy, r_sh_bx, r_sh_by;
  logic [CHP_W-1:0] r_sh_chp;
  logic [BHP_W-1:0] r_sh_bhp;

  logic [POS_W-1:0] r_char_x, r_char_y, r_boss_x, r_boss_y;
  logic [CHP_W-1:0] r_char_hp;
  logic [BHP_W-1:0] r_boss_hp;
  logic             r_on_ground, r_frame_valid, r_frame_err, r_link_up;
  logic [7:0]       r_err_cnt;

  logic       w_accept, w_bad, w_good, w_bad_acc, w_commit, w_drop;
  logic       w_gap_clr, w_gap_en, w_gap_exp, w_link_exp;
  logic [7:0] w_byte;

  // The FIFO head is consumed in the same cycle it is requested.
  assign rx.uart_rd = !rx.rx_empty && !rst;
  assign w_accept   = rx.uart_rd;
  assign w_byte     = rx.rx_data;
  assign w_bad      = |(w_byte & rsvd_mask(r_idx));
  assign w_good     = w_accept && !w_bad;
  assign w_bad_acc  = w_accept && w_bad;
  assign w_commit   = w_good && (r_idx == IDX_GND);
  assign w_drop     = w_bad_acc || w_gap_exp;

  assign w_gap_clr  = w_accept || (r_idx == IDX_CX_L);
  assign w_gap_en   = (r_idx != IDX_CX_L) && !w_accept;

  uart_game_timeout #(.TIMEOUT(GAP_TIMEOUT)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_gap_clr),
    .i_en     (w_gap_en),
    .o_expire (w_gap_exp)
  );

  uart_game_timeout #(.TIMEOUT(LINK_TIMEOUT)) u_link_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_commit),
    .i_en     (1'b1),
    .o_expire (w_link_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx         <= IDX_CX_L;
      r_sh_cx       <= '0;
      r_sh_cy       <= '0;
      r_sh_bx       <= '0;
      r_sh_by       <= '0;
      r_sh_chp      <= '0;
      r_sh_bhp      <= '0;
      r_char_x      <= '0;
      r_char_y      <= '0;
      r_char_hp     <= '0;
      r_boss_hp     <= '0;
      r_boss_x      <= '0;
      r_boss_y      <= '0;
      r_on_ground   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_cnt     <= '0;
      r_link_up     <= 1'b0;
    end else begin
      r_frame_valid <= w_commit;
      r_frame_err   <= w_drop;

      if (w_drop) begin
        r_idx <= IDX_CX_L;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end else if (w_good) begin
        r_idx <= w_commit ? IDX_CX_L : byte_idx_t'(r_idx + 4'd1);
      end

      if (w_good) begin
        case (r_idx)
          IDX_CX_L: r_sh_cx[7:0]  <= w_byte;
          IDX_CX_H: r_sh_cx[11:8] <= w_byte[3:0];
          IDX_CY_L: r_sh_cy[7:0]  <= w_byte;
          IDX_CY_H: r_sh_cy[11:8] <= w_byte[3:0];
          IDX_CHP:  r_sh_chp      <= w_byte[3:0];
          IDX_BHP:  r_sh_bhp      <= w_byte[6:0];
          IDX_BX_L: r_sh_bx[7:0]  <= w_byte;
          IDX_BX_H: r_sh_bx[11:8] <= w_byte[3:0];
          IDX_BY_L: r_sh_by[7:0]  <= w_byte;
          IDX_BY_H: r_sh_by[11:8] <= w_byte[3:0];
          default:  ;
        endcase
      end

      // GND is the final byte, so on_ground comes straight from the bus.
      if (w_commit) begin
        r_char_x    <= r_sh_cx;
        r_char_y    <= r_sh_cy;
        r_char_hp   <= r_sh_chp;
        r_boss_hp   <= r_sh_bhp;
        r_boss_x    <= r_sh_bx;
        r_boss_y    <= r_sh_by;
        r_on_ground <= w_byte[0];
      end

      if (w_commit) begin
        r_link_up <= 1'b1;
      end else if (w_link_exp) begin
        r_link_up <= 1'b0;
      end
    end
  end

  assign o_char_x      = r_char_x;
  assign o_char_y      = r_char_y;
  assign o_char_hp     = r_char_hp;
  assign o_boss_hp     = r_boss_hp;
  assign o_boss_x      = r_boss_x;
  assign o_boss_y      = r_boss_y;
  assign o_on_ground   = r_on_ground;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;
  assign o_err_cnt     = r_err_cnt;
  assign o_link_up     = r_link_up;

endmodule

`default_nettype wire

// File: tb/tb_uart_game_decoder.sv
//------------------------------------------------------------------------------
// tb_uart_game_decoder: randomized self-checking bench with a frame-level
// reference model of the decoder. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_game_decoder;

  localparam int GAP  = 16;
  localparam int LINK = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_game_rx_if #(.DATA_WIDTH(8)) rx_if ();

  logic [11:0] char_x, char_y, boss_x, boss_y;
  logic [3:0]  char_hp;
  logic [6:0]  boss_hp;
  logic        on_ground, frame_valid, frame_err, link_up;
  logic [7:0]  err_cnt;

  uart_game_decoder #(
    .DATA_WIDTH   (8),
    .GAP_TIMEOUT  (GAP),
    .LINK_TIMEOUT (LINK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx_if.slave),
    .o_char_x      (char_x),
    .o_char_y      (char_y),
    .o_char_hp     (char_hp),
    .o_boss_hp     (boss_hp),
    .o_boss_x      (boss_x),
    .o_boss_y      (boss_y),
    .o_on_ground   (on_ground),
    .o_frame_valid (frame_valid),
    .o_frame_err   (frame_err),
    .o_err_cnt     (err_cnt),
    .o_link_up     (link_up)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: a queue of good bytes of the frame in progress.
  int m_buf[$];
  int m_cx, m_cy, m_chp, m_bhp, m_bx, m_by, m_gnd;
  int m_fv, m_fe, m_err, m_link_up, m_gap, m_link_cnt;

  function automatic bit is_bad(input int pos, input int b);
    case (pos)
      1, 3, 4, 7, 9: return b > 15;
      5:             return b > 127;
      10:            return b > 1;
      default:       return 1'b0;
    endcase
  endfunction

  task automatic model_cycle(input bit do_rst, input bit acc, input int b);
    bit committed = 1'b0;
    if (do_rst) begin
      m_buf.delete();
      {m_cx, m_cy, m_chp, m_bhp, m_bx, m_by, m_gnd} = '0;
      {m_fv, m_fe, m_err, m_link_up, m_gap, m_link_cnt} = '0;
      return;
    end
    m_fv = 0;
    m_fe = 0;
    if (acc) begin
      m_gap = 0;
      if (is_bad(m_buf.size(), b)) begin
        m_buf.delete();
        m_fe  = 1;
        m_err = (m_err < 255) ? m_err + 1 : 255;
      end else begin
        m_buf.push_back(b);
        if (m_buf.size() == 11) begin
          m_cx  = m_buf[0] + 256 * m_buf[1];
          m_cy  = m_buf[2] + 256 * m_buf[3];
          m_chp = m_buf[4];
          m_bhp = m_buf[5];
          m_bx  = m_buf[6] + 256 * m_buf[7];
          m_by  = m_buf[8] + 256 * m_buf[9];
          m_gnd = m_buf[10];
          m_fv  = 1;
          committed = 1'b1;
          m_buf.delete();
        end
      end
    end else if (m_buf.size() > 0) begin
      m_gap++;
      if (m_gap == GAP) begin
        m_buf.delete();
        m_fe  = 1;
        m_err = (m_err < 255) ? m_err + 1 : 255;
        m_gap = 0;
      end
    end
    if (committed) begin
      m_link_cnt = 0;
      m_link_up  = 1;
    end else begin
      m_link_cnt++;
      if (m_link_cnt >= LINK) m_link_up = 0;
    end
  endtask

  logic [7:0] q[$];

  // One clock: drive at negedge, model the edge, compare every output after it.
  task automatic step(input bit gate, input bit do_rst);
    bit   avail, exp_rd;
    logic obs_rd;
    int   b = 0;
    @(negedge clk);
    rst   = do_rst;
    avail = (q.size() > 0) && gate;
    rx_if.rx_empty = !avail;
    rx_if.rx_data  = avail ? q[0] : 8'($urandom);
    exp_rd = avail && !do_rst;
    #1 obs_rd = rx_if.uart_rd;
    @(posedge clk);
    if (exp_rd) b = int'(q.pop_front());
    model_cycle(do_rst, exp_rd, b);
    #1;
    check_val("cycle",
      {obs_rd, char_x, char_y, char_hp, boss_hp, boss_x, boss_y, on_ground,
       frame_valid, frame_err, err_cnt, link_up},
      {exp_rd, 12'(m_cx), 12'(m_cy), 4'(m_chp), 7'(m_bhp), 12'(m_bx), 12'(m_by),
       1'(m_gnd), 1'(m_fv), 1'(m_fe), 8'(m_err), 1'(m_link_up)});
  endtask

  task automatic push_frame(input int x, y, hp, bhp, bx, by, gnd);
    q.push_back(8'(x));  q.push_back(8'(x >> 8));
    q.push_back(8'(y));  q.push_back(8'(y >> 8));
    q.push_back(8'(hp)); q.push_back(8'(bhp));
    q.push_back(8'(bx)); q.push_back(8'(bx >> 8));
    q.push_back(8'(by)); q.push_back(8'(by >> 8));
    q.push_back(8'(gnd));
  endtask

  task automatic push_rand_frame();
    push_frame($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 15),
               $urandom_range(0, 127), $urandom_range(0, 4095), $urandom_range(0, 4095),
               $urandom_range(0, 1));
  endtask

  task automatic drain(input bit toggle);
    int guard = 0;
    bit g = 1'b1;
    while (q.size() > 0 && guard < 2000) begin
      step(g, 1'b0);
      if (toggle) g = !g;
      guard++;
    end
    check_val("drain_bound", 128'(q.size()), 128'd0);
  endtask

  initial begin
    rx_if.rx_empty = 1'b1;
    rx_if.rx_data  = 8'h00;

    repeat (3) step(1'b1, 1'b1);
    check_val("reset_state",
      {char_x, char_y, char_hp, boss_hp, boss_x, boss_y, on_ground,
       frame_valid, frame_err, err_cnt, link_up}, 128'd0);

    // Reference frame, back to back
    q = '{8'h34, 8'h01, 8'h78, 8'h02, 8'h05, 8'h4B, 8'h00, 8'h03, 8'h20, 8'h01, 8'h01};
    drain(1'b0);
    check_val("a_cx", char_x, 12'h134);
    check_val("a_cy", char_y, 12'h278);
    check_val("a_chp", char_hp, 4'd5);
    check_val("a_bhp", boss_hp, 7'd75);
    check_val("a_bx", boss_x, 12'h300);
    check_val("a_by", boss_y, 12'h120);
    check_val("a_gnd_fv_link", {on_ground, frame_valid, link_up}, 3'b111);
    step(1'b1, 1'b0);
    check_val("a_fv_pulse", frame_valid, 1'b0);

    // Bad reserved bits in CX_H
    q = '{8'h34, 8'h11};
    drain(1'b0);
    check_val("bad_err", {frame_err, frame_valid, err_cnt}, {1'b1, 1'b0, 8'd1});
    check_val("bad_hold", char_x, 12'h134);
    push_frame(12'hABC, 12'h0F0, 9, 100, 12'h001, 12'hFFF, 0);
    drain(1'b0);
    check_val("b_fields", {char_x, char_y, char_hp, boss_hp, boss_x, boss_y, on_ground, frame_valid},
              {12'hABC, 12'h0F0, 4'd9, 7'd100, 12'h001, 12'hFFF, 1'b0, 1'b1});

    // Partial frame followed by a mid-frame gap
    q = '{8'h11, 8'h02, 8'h33, 8'h04, 8'h07};
    drain(1'b0);
    repeat (GAP - 1) step(1'b1, 1'b0);
    check_val("gap_early", frame_err, 1'b0);
    step(1'b1, 1'b0);
    check_val("gap_expire", {frame_err, err_cnt}, {1'b1, 8'd2});
    push_rand_frame();
    drain(1'b0);
    check_val("gap_recover", frame_valid, 1'b1);

    // rx_empty toggling every other cycle
    push_frame(12'h5A5, 12'h123, 15, 127, 12'h800, 12'h07F, 1);
    drain(1'b1);
    check_val("tog_fields", {char_x, char_y, char_hp, boss_hp, boss_x, boss_y, on_ground, frame_valid},
              {12'h5A5, 12'h123, 4'd15, 7'd127, 12'h800, 12'h07F, 1'b1, 1'b1});

    // Reset mid-frame after byte 7
    push_rand_frame();
    repeat (8) step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b1);
    check_val("rst_mid", {char_x, char_y, boss_x, boss_y, err_cnt, link_up}, 128'd0);
    q.delete();
    push_frame(12'h321, 12'h654, 3, 42, 12'h987, 12'h0AB, 1);
    drain(1'b0);
    check_val("rst_new", {char_x, char_y, char_hp, boss_hp, boss_x, boss_y, frame_valid, err_cnt},
              {12'h321, 12'h654, 4'd3, 7'd42, 12'h987, 12'h0AB, 1'b1, 8'd0});

    // Random frames with occasional corruption and random FIFO gaps
    for (int f = 0; f < 40; f++) begin
      push_rand_frame();
      if ($urandom_range(0, 3) == 0) begin
        int pos = $urandom_range(0, 10);
        q[q.size() - 11 + pos] = 8'($urandom);
      end
      while (q.size() > 0) step($urandom_range(0, 2) != 0, 1'b0);
    end

    // Error counter saturation
    for (int f = 0; f < 300; f++) begin
      q.push_back(8'h00);
      q.push_back(8'hF0);
    end
    drain(1'b0);
    step(1'b1, 1'b0);
    check_val("err_sat", err_cnt, 8'd255);

    // Link timeout after a final commit
    push_rand_frame();
    drain(1'b0);
    check_val("link_commit", {frame_valid, link_up}, 2'b11);
    repeat (LINK - 1) step(1'b1, 1'b0);
    check_val("link_last_up", link_up, 1'b1);
    step(1'b1, 1'b0);
    check_val("link_down", link_up, 1'b0);
    repeat (5) step(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
